// File: rtl/ap_data_line_if.sv
// Command/response bundle between the instruction sequencer and ap_data_line.
// The sequencer side drives the command fields; the data line answers with
// Ready, the cached cell value, its zero flag and the current address pointer.
interface ap_data_line_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4,
  parameter int ADDR_W     = 8
);
  logic                  CmdValid;
  logic [2:0]            CmdOp;
  logic [CNT_W-1:0]      CmdCount;
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  Ready;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataZero;
  logic [ADDR_W-1:0]     ApOut;

  modport master (
    output CmdValid, CmdOp, CmdCount, DataIn,
    input  Ready, DataOut, DataZero, ApOut
  );

  modport slave (
    input  CmdValid, CmdOp, CmdCount, DataIn,
    output Ready, DataOut, DataZero, ApOut
  );
endinterface

// File: rtl/ap_data_line.sv
// Address-pointer / data-cell line of the Brainfuck datapath.
// Holds the address pointer, a DEPTH-cell synchronous RAM and a single-cell
// write-back cache of cell[AP]. Repeat-counted pointer and data commands are
// taken over a valid/ready handshake; the cache is written back only when the
// pointer moves or on an explicit FLUSH.
module ap_data_line #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input logic           Clk,
  input logic           Rst_n,
  ap_data_line_if.slave bus
);

  // Controller states
  localparam logic [2:0] ST_CLEAR   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_WB      = 3'd2;
  localparam logic [2:0] ST_ACOUNT  = 3'd3;
  localparam logic [2:0] ST_FETCH_A = 3'd4;
  localparam logic [2:0] ST_FETCH_D = 3'd5;
  localparam logic [2:0] ST_DCOUNT  = 3'd6;

  // Command opcodes
  localparam logic [2:0] OP_AP_INC     = 3'b001;
  localparam logic [2:0] OP_AP_DEC     = 3'b010;
  localparam logic [2:0] OP_DATA_INC   = 3'b011;
  localparam logic [2:0] OP_DATA_DEC   = 3'b100;
  localparam logic [2:0] OP_DATA_WRITE = 3'b101;
  localparam logic [2:0] OP_FLUSH      = 3'b110;

  localparam logic [ADDR_W-1:0] AP_MAX = ADDR_W'(DEPTH - 1);

  // Pointer step modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [ADDR_W-1:0] ap_step(input logic [ADDR_W-1:0] ap,
                                                input logic down);
    logic [ADDR_W-1:0] res;
    if (down) begin
      res = (ap == {ADDR_W{1'b0}}) ? AP_MAX : ap - ADDR_W'(1);
    end else begin
      res = (ap == AP_MAX) ? {ADDR_W{1'b0}} : ap + ADDR_W'(1);
    end
    return res;
  endfunction

  // Cell step modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] data_step(input logic [DATA_WIDTH-1:0] d,
                                                      input logic down);
    logic [DATA_WIDTH-1:0] res;
    if (down) begin
      res = d - DATA_WIDTH'(1);
    end else begin
      res = d + DATA_WIDTH'(1);
    end
    return res;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_W-1:0]     ap_q, ap_d;
  logic [DATA_WIDTH-1:0] cache_q, cache_d;
  logic                  dirty_q, dirty_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [ADDR_W-1:0]     clr_q, clr_d;
  logic                  down_q, down_d;   // direction of the running count
  logic                  move_q, move_d;   // a pointer move follows the write-back
  logic                  ready_q, zero_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  mem_we_s;
  logic [ADDR_W-1:0]     mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  mem_re_s;
  logic                  accept_s;
  logic                  cnt_zero_s;

  assign accept_s   = bus.CmdValid && (state_q == ST_IDLE);
  assign cnt_zero_s = (bus.CmdCount == {CNT_W{1'b0}});

  // Next-state logic for the controller, pointer, cache and RAM ports
  always_comb begin
    state_d     = state_q;
    ap_d        = ap_q;
    cache_d     = cache_q;
    dirty_d     = dirty_q;
    step_d      = step_q;
    clr_d       = clr_q;
    down_d      = down_q;
    move_d      = move_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ap_q;
    mem_wdata_s = cache_q;
    mem_re_s    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_q;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (clr_q == AP_MAX) begin
          state_d = ST_IDLE;
          clr_d   = {ADDR_W{1'b0}};
          ap_d    = {ADDR_W{1'b0}};
          cache_d = {DATA_WIDTH{1'b0}};
          dirty_d = 1'b0;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end

      ST_IDLE: begin
        if (accept_s) begin
          case (bus.CmdOp)
            OP_AP_INC, OP_AP_DEC: begin
              if (!cnt_zero_s) begin
                step_d  = bus.CmdCount;
                down_d  = (bus.CmdOp == OP_AP_DEC);
                move_d  = 1'b1;
                state_d = dirty_q ? ST_WB : ST_ACOUNT;
              end else begin
                state_d = ST_IDLE;
              end
            end
            OP_DATA_INC, OP_DATA_DEC: begin
              if (!cnt_zero_s) begin
                step_d  = bus.CmdCount;
                down_d  = (bus.CmdOp == OP_DATA_DEC);
                dirty_d = 1'b1;
                state_d = ST_DCOUNT;
              end else begin
                state_d = ST_IDLE;
              end
            end
            OP_DATA_WRITE: begin
              cache_d = bus.DataIn;
              dirty_d = 1'b1;
            end
            OP_FLUSH: begin
              if (dirty_q) begin
                move_d  = 1'b0;
                state_d = ST_WB;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        mem_we_s = 1'b1;
        dirty_d  = 1'b0;
        if (move_q) begin
          state_d = ST_ACOUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACOUNT: begin
        ap_d   = ap_step(ap_q, down_q);
        step_d = step_q - CNT_W'(1);
        if (step_q == CNT_W'(1)) begin
          state_d = ST_FETCH_A;
        end else begin
          state_d = ST_ACOUNT;
        end
      end

      ST_FETCH_A: begin
        mem_re_s = 1'b1;
        state_d  = ST_FETCH_D;
      end

      ST_FETCH_D: begin
        cache_d = rd_q;
        state_d = ST_IDLE;
      end

      ST_DCOUNT: begin
        cache_d = data_step(cache_q, down_q);
        step_d  = step_q - CNT_W'(1);
        if (step_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DCOUNT;
        end
      end

      default: begin
        // Unreachable encoding: recover by re-running the clear sweep.
        state_d = ST_CLEAR;
        clr_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Controller and output registers with asynchronous reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_CLEAR;
      ap_q    <= {ADDR_W{1'b0}};
      cache_q <= {DATA_WIDTH{1'b0}};
      dirty_q <= 1'b0;
      step_q  <= {CNT_W{1'b0}};
      clr_q   <= {ADDR_W{1'b0}};
      down_q  <= 1'b0;
      move_q  <= 1'b0;
      ready_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ap_q    <= ap_d;
      cache_q <= cache_d;
      dirty_q <= dirty_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
      down_q  <= down_d;
      move_q  <= move_d;
      ready_q <= (state_d == ST_IDLE);
      zero_q  <= (cache_d == {DATA_WIDTH{1'b0}});
    end
  end

  // Cell RAM: synchronous write, registered read of the cell under AP
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
    if (mem_re_s) begin
      rd_q <= mem_q[ap_q];
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.DataOut  = cache_q;
  assign bus.DataZero = zero_q;
  assign bus.ApOut    = ap_q;

endmodule

// File: tb/tb_ap_data_line.sv
// Self-checking bench for ap_data_line with DEPTH=16: a vector table run
// through a scoreboard queue, plus hand-written reset sequences.
module tb_ap_data_line;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int AW    = 4;
  localparam int NVEC  = 22;
  localparam int BUDGET = 64;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] API = 3'b001;
  localparam logic [2:0] APD = 3'b010;
  localparam logic [2:0] DI  = 3'b011;
  localparam logic [2:0] DD  = 3'b100;
  localparam logic [2:0] DWR = 3'b101;
  localparam logic [2:0] FL  = 3'b110;
  localparam logic [2:0] RSV = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ap_data_line_if #(.DATA_WIDTH(DW), .CNT_W(CW), .ADDR_W(AW)) bus_if ();

  ap_data_line #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [2:0]    op;
    logic [CW-1:0] cnt;
    logic [DW-1:0] din;
    int            busy;
    logic [AW-1:0] ap;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count clock edges until Ready is high (0 if it already is).
  task automatic wait_ready(input string nm, output int cyc);
    cyc = 0;
    while (bus_if.Ready !== 1'b1 && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus_if.Ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: Ready still %0d after %0d cycles", nm, bus_if.Ready, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ready"}, int'(bus_if.Ready), 0);
    chk({nm, "_ap"},    int'(bus_if.ApOut), 0);
    chk({nm, "_data"},  int'(bus_if.DataOut), 0);
    chk({nm, "_zero"},  int'(bus_if.DataZero), 1);
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [DW-1:0] din);
    bus_if.CmdValid = 1'b1;
    bus_if.CmdOp    = op;
    bus_if.CmdCount = cnt;
    bus_if.DataIn   = din;
    @(posedge clk);
    #1;
    // Junk on the idle bus must be ignored while CmdValid is low.
    bus_if.CmdValid = 1'b0;
    bus_if.CmdOp    = DI;
    bus_if.CmdCount = 4'hF;
    bus_if.DataIn   = 8'hEE;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   busy;
    vec_t e;
    string nm;
    nm = $sformatf("v%0d", idx);
    sb.push_back(v);
    chk({nm, "_ready_pre"}, int'(bus_if.Ready), 1);
    drive_cmd(v.op, v.cnt, v.din);
    wait_ready(nm, busy);
    e = sb.pop_front();
    chk({nm, "_busy"}, busy, e.busy);
    chk({nm, "_ap"},   int'(bus_if.ApOut), int'(e.ap));
    chk({nm, "_data"}, int'(bus_if.DataOut), int'(e.data));
    chk({nm, "_zero"}, int'(bus_if.DataZero), (e.data == 8'h00) ? 1 : 0);
  endtask

  initial begin
    int cyc;
    bus_if.CmdValid = 1'b0;
    bus_if.CmdOp    = NOP;
    bus_if.CmdCount = 4'd0;
    bus_if.DataIn   = 8'h00;

    //            op   cnt    din    busy ap     data
    vecs[0]  = '{API, 4'd15, 8'h00, 17, 4'd15, 8'h00};
    vecs[1]  = '{API, 4'd1,  8'h00, 3,  4'd0,  8'h00};
    vecs[2]  = '{DD,  4'd1,  8'h00, 1,  4'd0,  8'hFF};
    vecs[3]  = '{DI,  4'd1,  8'h00, 1,  4'd0,  8'h00};
    vecs[4]  = '{DWR, 4'd0,  8'h5A, 0,  4'd0,  8'h5A};
    vecs[5]  = '{API, 4'd3,  8'h00, 6,  4'd3,  8'h00};
    vecs[6]  = '{APD, 4'd3,  8'h00, 5,  4'd0,  8'h5A};
    vecs[7]  = '{DI,  4'd0,  8'h00, 0,  4'd0,  8'h5A};
    vecs[8]  = '{NOP, 4'd5,  8'h33, 0,  4'd0,  8'h5A};
    vecs[9]  = '{RSV, 4'd7,  8'h44, 0,  4'd0,  8'h5A};
    vecs[10] = '{APD, 4'd1,  8'h00, 3,  4'd15, 8'h00};
    vecs[11] = '{DWR, 4'd0,  8'h11, 0,  4'd15, 8'h11};
    vecs[12] = '{FL,  4'd0,  8'h00, 1,  4'd15, 8'h11};
    vecs[13] = '{FL,  4'd0,  8'h00, 0,  4'd15, 8'h11};
    vecs[14] = '{API, 4'd1,  8'h00, 3,  4'd0,  8'h5A};
    vecs[15] = '{APD, 4'd1,  8'h00, 3,  4'd15, 8'h11};
    vecs[16] = '{DI,  4'd5,  8'h00, 5,  4'd15, 8'h16};
    vecs[17] = '{DD,  4'd3,  8'h00, 3,  4'd15, 8'h13};
    vecs[18] = '{API, 4'd2,  8'h00, 5,  4'd1,  8'h00};
    vecs[19] = '{APD, 4'd2,  8'h00, 4,  4'd15, 8'h13};
    vecs[20] = '{DWR, 4'd0,  8'h77, 0,  4'd15, 8'h77};
    vecs[21] = '{FL,  4'd0,  8'h00, 1,  4'd15, 8'h77};

    // Power-on reset and full clear sweep.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("por_clear", cyc);
    chk("por_clear_cycles", cyc, DEPTH);
    chk("por_idle_ap",   int'(bus_if.ApOut), 0);
    chk("por_idle_data", int'(bus_if.DataOut), 0);
    chk("por_idle_zero", int'(bus_if.DataZero), 1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the 3rd busy cycle of AP_INC 7 starting from AP=15.
    bus_if.CmdValid = 1'b1;
    bus_if.CmdOp    = API;
    bus_if.CmdCount = 4'd7;
    bus_if.DataIn   = 8'h00;
    @(posedge clk);
    #1;
    bus_if.CmdValid = 1'b0;
    chk("mid_busy", int'(bus_if.Ready), 0);
    @(posedge clk);
    #1;
    chk("mid_ap_step1", int'(bus_if.ApOut), 0);
    @(posedge clk);
    #1;
    chk("mid_ap_step2", int'(bus_if.ApOut), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("mid_clear", cyc);
    chk("mid_clear_cycles", cyc, DEPTH);
    chk("mid_idle_ap",   int'(bus_if.ApOut), 0);
    chk("mid_idle_data", int'(bus_if.DataOut), 0);

    // Cell 15 held 0x77 before the reset; the sweep must have cleared it.
    run_vec(NVEC, '{APD, 4'd1, 8'h00, 3, 4'd15, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
